clock_set_ctrl: RTL

Time-setting front end for the 24-hour digital clock. Debounces two raw push-buttons (MODE, INC) and walks an edit state machine (RUN → SET_HR → SET_MIN → RUN). It emits a one-cycle load of new hours/minutes into the downstream clock counter and a blink mask for the 4-digit multiplexed display. It sits directly upstream of the timekeeping counter; while `set_mode` is high the counter holds, and on `load` it takes `load_hours`/`load_minutes` and clears seconds.

---
 rtl/clock_set_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting front end for the 24-hour clock: debounced MODE/INC buttons drive
// an edit FSM that loads new hours/minutes downstream and blinks the edited digits.
//
//   state      | meaning
//   ST_RUN     | clock runs, buttons only arm editing
//   ST_SET_HR  | counter frozen, INC advances hours
//   ST_SET_MIN | counter frozen, INC advances minutes, MODE loads and exits
module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 12_500_000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic [4:0] cur_hours_i,
  input  logic [5:0] cur_minutes_i,
  output logic       set_mode_o,
  output logic       load_o,
  output logic [4:0] load_hours_o,
  output logic [5:0] load_minutes_o,
  output logic [3:0] blink_mask_o
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BKW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BKW-1:0] BK_LAST = BKW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_e;

  // Bit 0 is MODE, bit 1 is INC throughout the button path.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, stable_q, prev_q, arm_q, vld_q;
  logic [DBW-1:0] db_cnt_q [2];
  logic [1:0]     evt;
  logic           mode_evt, inc_evt;

  assign btn_raw = {btn_inc_i, btn_mode_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
      vld_q    <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      vld_q   <= {vld_q[0], 1'b1};
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] != stable_q[b]) begin
          if (db_cnt_q[b] == DB_LAST) begin
            stable_q[b] <= sync2_q[b];
            db_cnt_q[b] <= '0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + DBW'(1);
          end
        end else begin
          db_cnt_q[b] <= '0;
        end
        // A button held through reset must be seen released before it may fire.
        if (vld_q[1] && !sync2_q[b] && !stable_q[b]) arm_q[b] <= 1'b1;
      end
    end
  end

  assign evt      = stable_q & ~prev_q & arm_q;
  assign mode_evt = evt[0];
  assign inc_evt  = evt[1];

  state_e         state_q, state_d;
  logic [4:0]     hours_q, hours_d;
  logic [5:0]     minutes_q, minutes_d;
  logic           load_q, load_d;
  logic [BKW-1:0] blink_cnt_q, blink_cnt_d;
  logic           phase_q, phase_d;
  logic           blink_clr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      hours_q     <= '0;
      minutes_q   <= '0;
      load_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      load_q      <= load_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    load_d    = 1'b0;
    blink_clr = inc_evt;
    unique case (state_q)
      ST_RUN: begin
        if (mode_evt) begin
          hours_d   = cur_hours_i;
          minutes_d = cur_minutes_i;
          state_d   = ST_SET_HR;
          blink_clr = 1'b1;
        end
      end
      ST_SET_HR: begin
        if (mode_evt) begin
          state_d   = ST_SET_MIN;
          blink_clr = 1'b1;
        end else if (inc_evt) begin
          hours_d = (hours_q >= 5'd23) ? 5'd0 : hours_q + 5'd1;
        end
      end
      ST_SET_MIN: begin
        if (mode_evt) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (inc_evt) begin
          minutes_d = (minutes_q >= 6'd59) ? 6'd0 : minutes_q + 6'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (blink_clr) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BKW'(1);
      phase_d     = phase_q;
    end
  end

  always_comb begin
    blink_mask_o = 4'b0000;
    case (state_q)
      ST_SET_HR:  blink_mask_o = {phase_q, phase_q, 2'b00};
      ST_SET_MIN: blink_mask_o = {2'b00, phase_q, phase_q};
      default:    blink_mask_o = 4'b0000;
    endcase
  end

  assign set_mode_o     = (state_q != ST_RUN);
  assign load_o         = load_q;
  assign load_hours_o   = hours_q;
  assign load_minutes_o = minutes_q;

endmodule
